vga_timing_gen: RTL and testbench

Pixel-timing and output stage for the 640x480@60 VGA path. Generates the horizontal and vertical scan counters and drives `h_addr`/`v_addr` into the video memory. Takes the returned `vga_data` after a configurable read latency and re-aligns sync, blank and RGB so all output pins change on the same clock edge. It sits between the video memory and the board VGA pins.

---
 rtl/vga_pkg.sv | 64 ++++++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, control bundle and colour-bar table (bars used with VGA_TEST_PATTERN_EN)
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows: 656..751 and 490..491
    localparam logic [9:0] H_SYNC_FIRST = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_LAST  = H_ACTIVE + H_FP + H_SYNC - 10'd1;
    localparam logic [9:0] V_SYNC_FIRST = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_LAST  = V_ACTIVE + V_FP + V_SYNC - 10'd1;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    // Column / 80 without a divider; columns past 639 fall into bar 7 and are blanked anyway
    function automatic logic [2:0] bar_index(input logic [9:0] col);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++)
            if (col >= 10'(80 * i)) idx = 3'(i);
        return idx;
    endfunction

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - memory address/data and VGA pin bundle of the timing generator
interface vga_timing_gen_if;
    logic [23:0] vga_data;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;

    modport master (
        input  vga_data,
        output h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output vga_data,
        input  h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enable-gated shift register of configurable width/depth with async reset to INIT
module vga_delay_line #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 scan counters, memory addressing and pin-aligned output stage; VGA_TEST_PATTERN_EN adds colour bars
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int RD_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic test_mode,
`endif
    vga_timing_gen_if.master vga
);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    ctrl_t       ctrl0;
    ctrl_t       ctrl_d;
    logic [23:0] pix_src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == H_TOTAL - 10'd1) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        ctrl0     = CTRL_IDLE;
        ctrl0.act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
        ctrl0.hs  = !((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST));
        ctrl0.vs  = !((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST));
        ctrl0.fs  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga.h_addr <= '0;
            vga.v_addr <= '0;
        end else if (en) begin
            vga.h_addr <= ctrl0.act ? h_cnt : 10'd0;
            vga.v_addr <= ctrl0.act ? v_cnt : 10'd0;
        end
    end

    // One stage more than the memory latency: the address register is the extra one
`ifdef VGA_TEST_PATTERN_EN
    localparam int DLY_W = $bits(ctrl_t) + 3;
    localparam logic [DLY_W-1:0] DLY_INIT = {3'd0, CTRL_IDLE};
    logic [2:0]       bar_d;
    logic [DLY_W-1:0] dly_in;
    logic [DLY_W-1:0] dly_out;
    assign dly_in          = {bar_index(h_cnt), ctrl0};
    assign {bar_d, ctrl_d} = dly_out;
`else
    localparam int DLY_W = $bits(ctrl_t);
    localparam logic [DLY_W-1:0] DLY_INIT = CTRL_IDLE;
    logic [DLY_W-1:0] dly_in;
    logic [DLY_W-1:0] dly_out;
    assign dly_in = ctrl0;
    assign ctrl_d = dly_out;
`endif

    vga_delay_line #(
        .WIDTH (DLY_W),
        .DEPTH (RD_LAT + 1),
        .INIT  (DLY_INIT)
    ) u_ctrl_dly (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (dly_in),
        .dout (dly_out)
    );

    always_comb begin
        pix_src = vga.vga_data;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) pix_src = bar_color(bar_d);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.valid       <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.vga_r       <= '0;
            vga.vga_g       <= '0;
            vga.vga_b       <= '0;
        end else if (en) begin
            vga.hsync       <= ctrl_d.hs;
            vga.vsync       <= ctrl_d.vs;
            vga.valid       <= ctrl_d.act;
            vga.frame_start <= ctrl_d.fs;
            {vga.vga_r, vga.vga_g, vga.vga_b} <= ctrl_d.act ? pix_src : 24'h0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-enable bench for vga_timing_gen (RD_LAT 0 and 2) against a scan-position model
module tb_vga_timing_gen;

    localparam int FRAME = 800 * 525;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic        tm    = 1'b0;
    logic [23:0] salt0 = '0;
    logic [23:0] mp0   = '0;
    logic [23:0] mp1   = '0;
    int          n      = 0;
    int          checks = 0;
    int          errors = 0;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if2 ();

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_word(input logic [9:0] h, input logic [9:0] v, input logic [23:0] s);
        return {h[7:0], v[7:0], 8'hA5} ^ s;
    endfunction

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    vga_timing_gen #(.RD_LAT(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (tm),
`endif
        .vga       (if0)
    );

    vga_timing_gen #(.RD_LAT(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (tm),
`endif
        .vga       (if2)
    );

    // Memory: zero-latency lookup for dut0, two enabled cycles for dut2
    assign if0.vga_data = mem_word(if0.h_addr, if0.v_addr, salt0);
    always @(posedge clk) begin
        if (en) begin
            mp0 <= mem_word(if2.h_addr, if2.v_addr, 24'h0);
            mp1 <= mp0;
        end
    end
    assign if2.vga_data = mp1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    // Expected pins are the scan position (n - lat - 2) decoded; addresses are position (n - 1)
    task automatic check_dut(input string nm, input int lat, input logic [23:0] salt,
                             input logic [9:0] ha, input logic [9:0] va,
                             input logic hs, input logic vs, input logic vl, input logic fs,
                             input logic [23:0] rgb);
        int p, h, v;
        logic eact, ehs, evs, efs;
        logic [23:0] ergb;
        logic [9:0] eha, eva;
        eact = 1'b0; ehs = 1'b1; evs = 1'b1; efs = 1'b0; ergb = '0; eha = '0; eva = '0;
        if (n >= lat + 2) begin
            p = (n - lat - 2) % FRAME;
            h = p % 800;
            v = p / 800;
            eact = (h < 640) && (v < 480);
            ehs  = !(h >= 656 && h <= 751);
            evs  = !(v >= 490 && v <= 491);
            efs  = (p == 0);
            if (eact) ergb = tm ? bar_rgb(h / 80) : mem_word(10'(h), 10'(v), salt);
        end
        if (n >= 1) begin
            p = (n - 1) % FRAME;
            h = p % 800;
            v = p / 800;
            if (h < 640 && v < 480) begin
                eha = 10'(h);
                eva = 10'(v);
            end
        end
        check_eq({nm, "_h_addr"}, 32'(ha), 32'(eha));
        check_eq({nm, "_v_addr"}, 32'(va), 32'(eva));
        check_eq({nm, "_hsync"}, 32'(hs), 32'(ehs));
        check_eq({nm, "_vsync"}, 32'(vs), 32'(evs));
        check_eq({nm, "_valid"}, 32'(vl), 32'(eact));
        check_eq({nm, "_frame_start"}, 32'(fs), 32'(efs));
        check_eq({nm, "_rgb"}, 32'(rgb), 32'(ergb));
    endtask

    task automatic check_all();
        check_dut("d0", 0, salt0, if0.h_addr, if0.v_addr, if0.hsync, if0.vsync, if0.valid,
                  if0.frame_start, {if0.vga_r, if0.vga_g, if0.vga_b});
        check_dut("d2", 2, 24'h0, if2.h_addr, if2.v_addr, if2.hsync, if2.vsync, if2.valid,
                  if2.frame_start, {if2.vga_r, if2.vga_g, if2.vga_b});
    endtask

    task automatic step(input logic en_v);
        en = en_v;
        @(posedge clk);
        if (rst && en) n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b0;
        n   = 0;
        #1;
        check_all();
        repeat (hold) step(1'($urandom_range(0, 1)));
        rst = 1'b1;
    endtask

    initial begin
        int fs0_first, fs2_first, first_valid, first_hlow, vcount, hlow, k;
        fs0_first = -1; fs2_first = -1; first_valid = -1; first_hlow = -1;
        vcount = 0; hlow = 0; k = 0;
        salt0 = 24'($urandom);
        #2;
        do_reset(3);

        for (int i = 0; i < 2600 && errors <= 40; i++) begin
            step(1'b1);
            if (if0.frame_start && fs0_first < 0) fs0_first = n;
            if (if2.frame_start && fs2_first < 0) fs2_first = n;
            if (if0.valid && first_valid < 0) first_valid = n;
            if (!if0.hsync && first_hlow < 0) first_hlow = n;
            if (n >= 2 && n < 1602) begin
                vcount += int'(if0.valid);
                hlow   += int'(!if0.hsync);
            end
            if (n == 4 + 3 * 800 + 5)
                check_eq("d2_pixel_5_3", 32'({if2.vga_r, if2.vga_g, if2.vga_b}), 32'h0503A5);
        end
        check_eq("d0_first_frame_start", 32'(fs0_first), 32'd2);
        check_eq("d2_first_frame_start", 32'(fs2_first), 32'd4);
        check_eq("d0_hsync_offset", 32'(first_hlow - first_valid), 32'd656);
        check_eq("d0_valid_two_lines", 32'(vcount), 32'd1280);
        check_eq("d0_hsync_low_two_lines", 32'(hlow), 32'd192);

        for (int i = 0; i < 30000 && errors <= 40; i++)
            step(1'($urandom_range(0, 3) != 0));

        while (if0.h_addr != 10'd300 && k < 2000 && errors <= 40) begin
            step(1'b1);
            k++;
        end
        check_eq("d0_reach_h300", 32'(if0.h_addr), 32'd300);
        do_reset(2 + $urandom_range(0, 3));
        for (int i = 0; i < 4000 && errors <= 40; i++)
            step(1'($urandom_range(0, 3) != 0));

`ifdef VGA_TEST_PATTERN_EN
        tm = 1'b1;
        do_reset(2);
        for (int i = 0; i < 1000 && errors <= 40; i++) begin
            step(1'b1);
            if (n == 2)   check_eq("tp_col_0",   32'({if0.vga_r, if0.vga_g, if0.vga_b}), 32'hFFFFFF);
            if (n == 87)  check_eq("tp_col_85",  32'({if0.vga_r, if0.vga_g, if0.vga_b}), 32'hFFFF00);
            if (n == 641) check_eq("tp_col_639", 32'({if0.vga_r, if0.vga_g, if0.vga_b}), 32'h000000);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
